instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hBFC00000, byte address of the first memory location.
REQ-002 SHALL have parameter ADDR_W, default 12, log2 of memory size in bytes; legal range 4..16.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction emitted when the output is not valid.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port PC_F  in  32  fetch byte address.
REQ-007 SHALL have port Req_F  in  1  fetch request valid.
REQ-008 SHALL have port Stall_F  in  1  hold the output stage; a new request is not accepted.
REQ-009 SHALL have port Flush_D  in  1  invalidate the output stage.
REQ-010 SHALL have port Instr_D  out  32  fetched instruction, little-endian.
REQ-011 SHALL have port Valid_D  out  1  Instr_D holds a fetched instruction.
REQ-012 SHALL have port Fault_D  out  1  the fetch was out of range or misaligned.
REQ-013 SHALL have port Ld_WE  in  1  program-load write enable.
REQ-014 SHALL have port Ld_Addr  in  ADDR_W  load byte offset, word-aligned; bits [1:0] are ignored.
REQ-015 SHALL have port Ld_Data  in  32  load word.
REQ-016 SHALL have port Ld_BE  in  4  byte enables for Ld_Data; bit 0 = lowest byte.

Function
REQ-017 SHALL store 2**ADDR_W bytes; contents are not cleared by rst.
REQ-018 SHALL treat a fetch as in range when PC_F[31:ADDR_W] == BASE_ADDR[31:ADDR_W].
REQ-019 SHALL treat a fetch as aligned when PC_F[1:0] == 2'b00.
REQ-020 SHALL accept a request when Req_F=1 and Stall_F=0; the result appears on the next edge (1-cycle latency).
REQ-021 On an accepted in-range aligned fetch: Instr_D = {mem[o+3],mem[o+2],mem[o+1],mem[o]}, where o = PC_F[ADDR_W-1:0]; Valid_D=1; Fault_D=0.
REQ-022 On an accepted out-of-range or misaligned fetch: Instr_D=NOP_INSTR; Valid_D=1; Fault_D per REQ-033/034.
REQ-023 With Req_F=0 and Stall_F=0: on the next edge Valid_D=0, Instr_D=NOP_INSTR, Fault_D=0.
REQ-024 With Stall_F=1 and Flush_D=0: Instr_D, Valid_D and Fault_D hold, and PC_F is ignored.
REQ-025 With Flush_D=1: on the next edge Valid_D=0, Instr_D=NOP_INSTR, Fault_D=0; Flush_D overrides Stall_F and Req_F.
REQ-026 A load write SHALL update each byte whose Ld_BE bit is 1 at Ld_Addr on the edge where Ld_WE=1.
REQ-027 A load write and a fetch of the same word in the same cycle SHALL return the pre-write data (read-before-write).
REQ-028 A load write SHALL NOT alter Instr_D while a stall holds it.
REQ-029 The offset arithmetic SHALL wrap modulo 2**ADDR_W; the offset is always aligned, so no fetch crosses the top of memory.

Reset
REQ-030 While rst=1, on each edge: Valid_D=0, Instr_D=NOP_INSTR, Fault_D=0; fetch requests are ignored.
REQ-031 A load write SHALL still be performed while rst=1, so a program can be loaded under reset.
REQ-032 Reset asserted mid-stall SHALL discard the held output; the first request after deassertion is accepted normally.

Configuration
REQ-033 With IMEM_FAULT_EN defined, Fault_D=1 for any accepted fetch that is out of range or misaligned.
REQ-034 Without IMEM_FAULT_EN, Fault_D is constant 0 and a faulting fetch only yields NOP_INSTR with Valid_D=1.

Verification
REQ-035 Load 0x00500093 at offset 0x010 with Ld_BE=4'hF; fetch PC_F=0xBFC00010 -> next cycle Instr_D=0x00500093, Valid_D=1, Fault_D=0.
REQ-036 Fetch PC_F=0xBFC00010, then assert Stall_F for 3 cycles while PC_F=0xBFC00020 -> Instr_D stays 0x00500093 for all 3 cycles.
REQ-037 Assert Stall_F=1 and Flush_D=1 together -> next cycle Valid_D=0, Instr_D=0x00000013.
REQ-038 With IMEM_FAULT_EN: fetch PC_F=0x00001000, then PC_F=0xBFC00002 -> each returns Instr_D=0x00000013, Valid_D=1, Fault_D=1; without IMEM_FAULT_EN, Fault_D=0.
REQ-039 In one cycle, write 0xAABBCCDD with Ld_BE=4'b0011 at offset 0x010 and fetch 0xBFC00010 -> that fetch returns old 0x00500093; the next fetch returns 0x0050CCDD.
REQ-040 Assert rst for 1 cycle during a stalled valid output -> Valid_D=0 next cycle; a following fetch of 0xBFC00010 returns the stored word.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a registered fetch port (1-cycle latency) and a byte-enabled program-load write port.
// Stall_F holds the output and blocks new requests. Flush_D and rst clear it. IMEM_FAULT_EN enables Fault_D.
module instr_fetch_mem #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_F,
  input  logic              Req_F,
  input  logic              Stall_F,
  input  logic              Flush_D,
  output logic [31:0]       Instr_D,
  output logic              Valid_D,
  output logic              Fault_D,
  input  logic              Ld_WE,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [31:0]       Ld_Data,
  input  logic [3:0]        Ld_BE
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  logic [31:0]       mem [0:WORDS-1];
  logic [ADDR_W-3:0] fetch_idx;
  logic [ADDR_W-3:0] load_idx;
  logic              in_range;
  logic              aligned;
  logic              fetch_ok;
  logic              accept;
  logic [1:0]        unused_ld_lsb;

  assign fetch_idx     = PC_F[ADDR_W-1:2];
  assign load_idx      = Ld_Addr[ADDR_W-1:2];
  assign unused_ld_lsb = Ld_Addr[1:0];
  assign in_range      = (PC_F[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  assign aligned       = (PC_F[1:0] == 2'b00);
  assign fetch_ok      = in_range && aligned;
  assign accept        = Req_F && !Stall_F;

  // Program load is independent of rst so code can be loaded while the core is held in reset.
  always_ff @(posedge clk) begin
    if (Ld_WE) begin
      for (int b = 0; b < 4; b++) begin
        if (Ld_BE[b]) mem[load_idx][8*b +: 8] <= Ld_Data[8*b +: 8];
      end
    end
  end

  // Reading mem here sees the pre-write contents, giving read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst || Flush_D) begin
      Valid_D <= 1'b0;
      Instr_D <= NOP_INSTR;
    end else if (!Stall_F) begin
      Valid_D <= accept;
      Instr_D <= (accept && fetch_ok) ? mem[fetch_idx] : NOP_INSTR;
    end
  end

`ifdef IMEM_FAULT_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst || Flush_D) begin
      fault_q <= 1'b0;
    end else if (!Stall_F) begin
      fault_q <= accept && !fetch_ok;
    end
  end

  assign Fault_D = fault_q;
`else
  assign Fault_D = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed-vector bench for instr_fetch_mem with default parameters.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_F;
  logic        Req_F;
  logic        Stall_F;
  logic        Flush_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic        Fault_D;
  logic        Ld_WE;
  logic [11:0] Ld_Addr;
  logic [31:0] Ld_Data;
  logic [3:0]  Ld_BE;

  int nvec = 0;
  int nerr = 0;

`ifdef IMEM_FAULT_EN
  localparam logic FEXP = 1'b1;
`else
  localparam logic FEXP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  instr_fetch_mem dut (
    .clk     (clk),
    .rst     (rst),
    .PC_F    (PC_F),
    .Req_F   (Req_F),
    .Stall_F (Stall_F),
    .Flush_D (Flush_D),
    .Instr_D (Instr_D),
    .Valid_D (Valid_D),
    .Fault_D (Fault_D),
    .Ld_WE   (Ld_WE),
    .Ld_Addr (Ld_Addr),
    .Ld_Data (Ld_Data),
    .Ld_BE   (Ld_BE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic vld, input logic flt);
    chk({tag, ".instr"}, Instr_D, ins);
    chk({tag, ".valid"}, {31'b0, Valid_D}, {31'b0, vld});
    chk({tag, ".fault"}, {31'b0, Fault_D}, {31'b0, flt});
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    Ld_WE = 1'b1; Ld_Addr = a; Ld_Data = d; Ld_BE = be;
  endtask

  initial begin
    rst = 1'b1; PC_F = 32'hBFC00010; Req_F = 1'b1; Stall_F = 1'b0; Flush_D = 1'b0;
    Ld_WE = 1'b0; Ld_Addr = '0; Ld_Data = '0; Ld_BE = '0;

    // Program load under reset; the concurrent fetch request must be ignored.
    load(12'h010, 32'h00500093, 4'hF);
    step;
    chk_out("reset", NOP, 1'b0, 1'b0);
    load(12'h020, 32'h12345678, 4'hF);
    step;
    load(12'hFFC, 32'hDEADBEEF, 4'hF);
    step;
    chk_out("reset2", NOP, 1'b0, 1'b0);
    Ld_WE = 1'b0;
    rst = 1'b0;

    // Basic fetch
    PC_F = 32'hBFC00010; Req_F = 1'b1;
    step;
    chk_out("fetch10", 32'h00500093, 1'b1, 1'b0);

    // Stall for 3 cycles with a new PC and a concurrent load to another word
    Stall_F = 1'b1; PC_F = 32'hBFC00020;
    load(12'h020, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step;
      Ld_WE = 1'b0;
      chk("stall.instr", Instr_D, 32'h00500093);
      chk("stall.valid", {31'b0, Valid_D}, 32'd1);
    end
    Stall_F = 1'b0;
    step;
    chk_out("fetch20", 32'hCAFEF00D, 1'b1, 1'b0);

    // Idle
    Req_F = 1'b0;
    step;
    chk_out("idle", NOP, 1'b0, 1'b0);

    // Top word of memory
    Req_F = 1'b1; PC_F = 32'hBFC00FFC;
    step;
    chk_out("topword", 32'hDEADBEEF, 1'b1, 1'b0);

    // Flush overrides stall
    Stall_F = 1'b1; Flush_D = 1'b1;
    step;
    chk_out("flush", NOP, 1'b0, 1'b0);
    Stall_F = 1'b0; Flush_D = 1'b0;

    // Faulting fetches
    PC_F = 32'h00001000;
    step;
    chk_out("oor", NOP, 1'b1, FEXP);
    PC_F = 32'hBFC00002;
    step;
    chk_out("misalign", NOP, 1'b1, FEXP);
    PC_F = 32'hBFC01000;
    step;
    chk_out("pastend", NOP, 1'b1, FEXP);

    // Read-before-write on the same word, partial byte enables
    PC_F = 32'hBFC00010;
    load(12'h010, 32'hAABBCCDD, 4'b0011);
    step;
    Ld_WE = 1'b0;
    chk_out("rbw_old", 32'h00500093, 1'b1, 1'b0);
    step;
    chk_out("rbw_new", 32'h0050CCDD, 1'b1, 1'b0);

    // Reset during a stalled valid output
    Stall_F = 1'b1; Req_F = 1'b0;
    step;
    chk_out("hold", 32'h0050CCDD, 1'b1, 1'b0);
    rst = 1'b1;
    step;
    chk_out("rst_stall", NOP, 1'b0, 1'b0);
    rst = 1'b0; Stall_F = 1'b0; Req_F = 1'b1; PC_F = 32'hBFC00010;
    step;
    chk_out("after_rst", 32'h0050CCDD, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
